multiplier_array_pipe_hs: RTL
=============================

// Module: multiplier_array_pipe_hs
// PURPOSE
//  Parametrised pipelined array multiplier with valid/ready flow control and per-operand signed/unsigned mode.
//  Partial-product rows of the array are split evenly across `stages` register stages.
//  Accepts one product per cycle and supports backpressure from the consumer.
//  Drop-in successor to the fixed-latency array multiplier for datapaths that stall.
// PARAMETERS
//  width   8   operand width in bits (>=2); product is 2*width bits
//  stages  4   pipeline register stages, 1..width; latency in cycles when not stalled
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous reset, active-high
//  in_valid     in   1        a, b, signed_mode are valid this cycle
//  in_ready     out  1        block accepts input this cycle
//  a            in   width    multiplicand
//  b            in   width    multiplier
//  signed_mode  in   1        1: a, b and y are two's complement; 0: unsigned
//  out_valid    out  1        y holds a completed product
//  out_ready    in   1        consumer takes y this cycle
//  y            out  2*width  product a*b
// BEHAVIOUR
//  - Reset (async, immediate): all stage valid bits = 0, all stage data = 0; out_valid = 0, y = 0.
//    in_ready = 1 once rst is released.
//  - Advance signal: adv = !out_valid || out_ready. in_ready = adv (combinational).
//    When adv = 1, every stage loads from its predecessor. When adv = 0, all stages hold.
//  - Input transfer: in_valid && in_ready. If in_valid = 0 while adv = 1, a bubble (valid = 0) enters stage 0.
//  - Output transfer: out_valid && out_ready. While out_ready = 0, y and out_valid are held stable.
//  - Latency: exactly `stages` cycles from input transfer to out_valid when never stalled.
//    Each stall cycle adds one cycle. Throughput is 1 per cycle.
//  - Row mapping: stage k (0..stages-1) adds partial-product rows [k*R, min((k+1)*R, width)), where R = ceil(width/stages).
//    Stages with no rows act as pure delay. a, b and signed_mode travel with their partial sum.
//    Mode may change every cycle; each item uses its own sampled mode.
//  - Arithmetic: accumulators are 2*width bits; no overflow is possible.
//    Unsigned: y = a*b.
//    Signed: y = $signed(a)*$signed(b), full-precision 2*width-bit two's complement.
//    Use Baugh-Wooley or sign-extended rows; MSB row of b is subtracted.
//  - Last stage: y = last-stage sum register, out_valid = last-stage valid bit.
//    Both are registered outputs; there is no combinational path from a or b to y.
//  - Data of bubble stages is don't-care internally. y is only required to be meaningful while out_valid = 1.
//  - Simultaneous input and output transfer in the same cycle is legal. No item is lost or duplicated.
//  - Reset mid-operation: every in-flight item is discarded. Nothing emerges after release until new input.
//  - stages = 1: the whole array is combinational into a single register; latency 1.
// TESTING
//  1. width=8, stages=4, unsigned, 0xFF*0xFF, out_ready=1
//     -> y=0xFE01 with out_valid=1 exactly 4 cycles after the transfer; 1-cycle pulse.
//  2. Signed: 0x80*0x80 -> 0x4000; 0xFF*0x01 -> 0xFFFF; 0x7F*0x80 -> 0xC080.
//     Unsigned 0x80*0x80 -> 0x4000.
//  3. Alternating modes back-to-back, 0xFF*0x02: unsigned -> 0x01FE, then signed -> 0xFFFE.
//     Results arrive in order on consecutive cycles.
//  4. Stream of 8 items, out_ready low for 3 cycles mid-stream -> y/out_valid frozen, in_ready=0.
//     All 8 results emerge in order, none lost or duplicated.
//  5. 3 items in flight, pulse rst asynchronously between edges -> out_valid=0 and y=0 immediately.
//     No output after release until new input; first new item returns after 4 cycles.
//  6. 2000 random operands and modes, random in_valid/out_ready, width in {4,8,13}, stages in {1,3,width}
//     -> every y matches the reference a*b model in order.

Source files
------------

// File: rtl/multiplier_array_pipe_hs.sv
// ---------------------------------------------------------------------------
// multiplier_array_pipe_hs
//
// Pipelined array multiplier with valid/ready flow control and a per-item
// signed/unsigned mode. The partial-product rows of a width x width array are
// spread evenly over `stages` register stages. Each stage carries its running
// partial sum along with the operands and the mode bit, so every item is
// finished with the mode it was sampled with. The whole pipe advances as one
// unit whenever the output register is empty or being drained, which gives a
// throughput of one product per cycle and lossless backpressure.
//
// Parameters
//   width   operand width in bits (>= 2); the product is 2*width bits
//   stages  number of register stages (1..width); unstalled latency in cycles
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active high
//   in_valid     a, b and signed_mode carry an item this cycle
//   in_ready     pipe can accept an item this cycle
//   a            multiplicand
//   b            multiplier
//   signed_mode  1: a, b and y are two's complement, 0: unsigned
//   out_valid    y holds a finished product
//   out_ready    consumer takes y this cycle
//   y            registered product a*b
// ---------------------------------------------------------------------------
module multiplier_array_pipe_hs #(
   parameter int width  = 8,
   parameter int stages = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [width-1:0]     a,
   input  logic [width-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*width-1:0]   y
);

   localparam int ProdWidth = 2 * width;
   localparam int RowsPerStage = (width + stages - 1) / stages;

   // Adds the partial-product rows lo..hi-1 of opA*opB to sumIn. In signed
   // mode the multiplicand is sign-extended to the full product width and the
   // row belonging to the sign bit of opB is subtracted, since that bit has a
   // weight of -2^(width-1). All arithmetic wraps at 2*width bits, which is
   // exactly the width of a full-precision product, so nothing overflows.
   function automatic logic [ProdWidth-1:0] addRows(
      input logic [ProdWidth-1:0] sumIn,
      input logic [width-1:0]     opA,
      input logic [width-1:0]     opB,
      input logic                 mode,
      input int                   lo,
      input int                   hi
   );
      logic [ProdWidth-1:0] acc;
      logic [ProdWidth-1:0] aExt;
      logic [ProdWidth-1:0] row;
      acc  = sumIn;
      aExt = mode ? {{width{opA[width-1]}}, opA} : {{width{1'b0}}, opA};
      row  = '0;
      for (int j = 0; j < width; j++) begin
         if (j >= lo && j < hi && opB[j]) begin
            row = aExt << j;
            if (mode && j == width - 1) begin
               acc = acc - row;
            end else begin
               acc = acc + row;
            end
         end
      end
      return acc;
   endfunction

   logic                 valid_q [stages];
   logic                 valid_d [stages];
   logic [ProdWidth-1:0] sum_q   [stages];
   logic [ProdWidth-1:0] sum_d   [stages];
   logic [width-1:0]     opA_q   [stages];
   logic [width-1:0]     opA_d   [stages];
   logic [width-1:0]     opB_q   [stages];
   logic [width-1:0]     opB_d   [stages];
   logic                 mode_q  [stages];
   logic                 mode_d  [stages];

   logic                 predValid [stages];
   logic [ProdWidth-1:0] predSum   [stages];
   logic [width-1:0]     predA     [stages];
   logic [width-1:0]     predB     [stages];
   logic                 predMode  [stages];

   logic adv;

   // The pipe moves forward only when the output slot is free or is being
   // taken this cycle; otherwise every stage holds. Accepting input is tied to
   // the same condition, so an item can never be pushed into a frozen pipe.
   always_comb begin
      adv = !valid_q[stages-1] || out_ready;
   end

   // Each stage's predecessor: stage 0 is fed straight from the input ports
   // with an empty partial sum, every later stage from the register in front
   // of it. A cycle without in_valid pushes a bubble into stage 0.
   always_comb begin
      predValid[0] = in_valid;
      predSum[0]   = '0;
      predA[0]     = a;
      predB[0]     = b;
      predMode[0]  = signed_mode;
      for (int k = 1; k < stages; k++) begin
         predValid[k] = valid_q[k-1];
         predSum[k]   = sum_q[k-1];
         predA[k]     = opA_q[k-1];
         predB[k]     = opB_q[k-1];
         predMode[k]  = mode_q[k-1];
      end
   end

   // Next-state for every stage: add this stage's slice of rows to the sum
   // coming from the predecessor. Stages whose row range is empty (possible
   // when width does not divide evenly) simply pass the sum through.
   always_comb begin
      for (int k = 0; k < stages; k++) begin
         int lo;
         int hi;
         lo = k * RowsPerStage;
         hi = (k + 1) * RowsPerStage;
         if (hi > width) begin
            hi = width;
         end
         valid_d[k] = predValid[k];
         opA_d[k]   = predA[k];
         opB_d[k]   = predB[k];
         mode_d[k]  = predMode[k];
         sum_d[k]   = addRows(predSum[k], predA[k], predB[k], predMode[k], lo, hi);
      end
   end

   // Stage registers. Reset clears everything, which discards any in-flight
   // items and forces the output to zero at once. Without reset, all stages
   // load together on an advance cycle and hold together on a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < stages; k++) begin
            valid_q[k] <= 1'b0;
            sum_q[k]   <= '0;
            opA_q[k]   <= '0;
            opB_q[k]   <= '0;
            mode_q[k]  <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < stages; k++) begin
            valid_q[k] <= valid_d[k];
            sum_q[k]   <= sum_d[k];
            opA_q[k]   <= opA_d[k];
            opB_q[k]   <= opB_d[k];
            mode_q[k]  <= mode_d[k];
         end
      end
   end

   // The last stage is the output register, so y never sees a combinational
   // path from the operand inputs.
   always_comb begin
      in_ready  = adv;
      out_valid = valid_q[stages-1];
      y         = sum_q[stages-1];
   end

endmodule
